// File: rtl/definitions_pkg.sv
// Shared core definitions: instruction encoding, memory opcodes and LSU state type.
package definitions;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned INSTR_W  = OPCODE_W + 2 * REG_W;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs;
    } instruction_s;

    localparam logic [OPCODE_W-1:0] OPC_LW  = 8'h10;
    localparam logic [OPCODE_W-1:0] OPC_LBU = 8'h11;
    localparam logic [OPCODE_W-1:0] OPC_SW  = 8'h18;
    localparam logic [OPCODE_W-1:0] OPC_SB  = 8'h19;

    // Register fields are don't-care for decode
    localparam logic [INSTR_W-1:0] kLW  = {OPC_LW,  8'b????????};
    localparam logic [INSTR_W-1:0] kLBU = {OPC_LBU, 8'b????????};
    localparam logic [INSTR_W-1:0] kSW  = {OPC_SW,  8'b????????};
    localparam logic [INSTR_W-1:0] kSB  = {OPC_SB,  8'b????????};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Byte-lane steering: load byte select/zero-extend, store byte replicate and byte enables.
module lsu_byte_lane (
    input  logic        is_byte,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] load_data_c
);

    always_comb begin
        be_c        = 4'hF;
        wdata_c     = store_data;
        load_data_c = rdata;
        if (is_byte) begin
            be_c        = 4'b0001 << addr_lo;
            wdata_c     = {4{store_data[7:0]}};
            load_data_c = 32'(rdata[{addr_lo, 3'b000} +: 8]);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: one valid/ready request at a time, stalls the pipe until done.
// Optional misaligned word-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
import definitions::*;

module load_store_unit #(
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid_i,
    input  instruction_s          op_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           store_data_i,
    output logic                  stall_o,
    output logic                  wb_valid_o,
    output logic [31:0]           wb_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [31:0]           mem_rdata_i
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    lsu_state_e  state;
    logic        is_load_q;
    logic        is_byte_q;
    logic [1:0]  addr_lo_q;

    logic        is_lw, is_lbu, is_sw, is_sb;
    logic        trigger, misaligned;
    logic        lane_is_byte;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load_data;

    // Opcode decode and trigger; stall is the only combinational output
    always_comb begin
        is_lw   = (op_i ==? kLW);
        is_lbu  = (op_i ==? kLBU);
        is_sw   = (op_i ==? kSW);
        is_sb   = (op_i ==? kSB);
        trigger = (state == IDLE) && op_valid_i && (is_lw || is_lbu || is_sw || is_sb);
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned = (is_lw || is_sw) && (addr_i[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        stall_o = (state == REQ) || (state == RESP) || trigger;
    end

    // Store formatting uses live operands at trigger; load formatting uses captured ones
    always_comb begin
        lane_is_byte = is_byte_q;
        lane_addr_lo = addr_lo_q;
        if (state == IDLE) begin
            lane_is_byte = is_lbu || is_sb;
            lane_addr_lo = addr_i[1:0];
        end
    end

    lsu_byte_lane u_byte_lane (
        .is_byte     (lane_is_byte),
        .addr_lo     (lane_addr_lo),
        .store_data  (store_data_i),
        .rdata       (mem_rdata_i),
        .be_c        (lane_be),
        .wdata_c     (lane_wdata),
        .load_data_c (lane_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            is_load_q       <= 1'b0;
            is_byte_q       <= 1'b0;
            addr_lo_q       <= 2'b00;
            wb_valid_o      <= 1'b0;
            wb_data_o       <= 32'h0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_we_o        <= 1'b0;
            mem_be_o        <= 4'h0;
            mem_wdata_o     <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_o      <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (trigger) begin
                        is_load_q <= is_lw || is_lbu;
                        is_byte_q <= is_lbu || is_sb;
                        addr_lo_q <= addr_i[1:0];
                        if (misaligned) begin
                            state      <= DONE;
                            wb_valid_o <= is_lw;
                            wb_data_o  <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
                            misalign_o <= 1'b1;
`endif
                        end else begin
                            state           <= REQ;
                            mem_req_valid_o <= 1'b1;
                            mem_we_o        <= is_sw || is_sb;
                            mem_addr_o      <= MEM_ADDR_W'({addr_i[31:2], 2'b00});
                            mem_be_o        <= lane_be;
                            mem_wdata_o     <= lane_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        mem_we_o        <= 1'b0;
                        state           <= is_load_q ? RESP : DONE;
                    end
                end
                RESP: begin
                    if (mem_rsp_valid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_data_o  <= lane_load_data;
                        state      <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses vs a reference model.
import definitions::*;

module tb_load_store_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid_i;
    instruction_s op_i;
    logic [31:0]  addr_i, store_data_i;
    logic         stall_o, wb_valid_o;
    logic [31:0]  wb_data_o;
    logic         mem_req_valid_o, mem_req_ready_i;
    logic [31:0]  mem_addr_o;
    logic         mem_we_o;
    logic [3:0]   mem_be_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_rsp_valid_i;
    logic [31:0]  mem_rdata_i;
`ifdef LSU_MISALIGN_CHECK_EN
    logic         misalign_o;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Observations gathered by run_op
    int           obs_stall, obs_req, obs_wb, obs_extra_req;
    bit           obs_timeout, obs_wb_in_done, obs_mis_in_done;
    logic [31:0]  obs_addr, obs_wdata, obs_wb_data;
    logic [3:0]   obs_be;
    logic         obs_we;
    logic [31:0]  model_wb;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .op_valid_i      (op_valid_i),
        .op_i            (op_i),
        .addr_i          (addr_i),
        .store_data_i    (store_data_i),
        .stall_o         (stall_o),
        .wb_valid_o      (wb_valid_o),
        .wb_data_o       (wb_data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rdata_i     (mem_rdata_i)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .misalign_o      (misalign_o)
`endif
    );

    // Drive one instruction and act as a memory with given ready delay and response latency
    task automatic run_op(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d,
                          input int rdly, input int rspd, input logic [31:0] rdat, input int tail);
        int cyc, reqc, hs;
        bit done;
        obs_stall = 0; obs_req = 0; obs_wb = 0; obs_extra_req = 0;
        obs_timeout = 0; obs_wb_in_done = 0; obs_mis_in_done = 0;
        obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0; obs_wb_data = 0;
        cyc = 0; reqc = 0; hs = -1; done = 0;
        @(negedge clk);
        op_valid_i   = 1'b1;
        op_i.opcode  = opc;
        op_i.rd      = 4'($urandom);
        op_i.rs      = 4'($urandom);
        addr_i       = a;
        store_data_i = d;
        while (!done && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            mem_req_ready_i = mem_req_valid_o && (reqc == rdly);
            mem_rsp_valid_i = (hs >= 0) && (cyc == hs + rspd);
            mem_rdata_i     = mem_rsp_valid_i ? rdat : $urandom();
            #1;
            if (mem_req_valid_o) begin
                if (mem_req_ready_i) begin
                    obs_req++;
                    obs_addr  = mem_addr_o;
                    obs_be    = mem_be_o;
                    obs_we    = mem_we_o;
                    obs_wdata = mem_wdata_o;
                    hs        = cyc;
                end
                reqc++;
            end
            if (wb_valid_o) begin
                obs_wb++;
                obs_wb_data = wb_data_o;
            end
            if (stall_o) obs_stall++;
            else begin
                done = 1;
                obs_wb_in_done = wb_valid_o;
`ifdef LSU_MISALIGN_CHECK_EN
                obs_mis_in_done = misalign_o;
`endif
            end
            cyc++;
        end
        if (!done) obs_timeout = 1;
        for (int t = 0; t < tail; t++) begin
            @(negedge clk);
            op_valid_i      = 1'b0;
            mem_req_ready_i = 1'b1;
            mem_rsp_valid_i = 1'b0;
            #1;
            if (wb_valid_o) obs_wb++;
            if (mem_req_valid_o) obs_extra_req++;
        end
        mem_req_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid_i = 0; op_i = '0; addr_i = 0; store_data_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rdata_i = 0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if ({stall_o, wb_valid_o, mem_req_valid_o, mem_we_o} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {stall_o, wb_valid_o, mem_req_valid_o, mem_we_o}); else n_pass++;
        n_total++; if ({wb_data_o, mem_addr_o, mem_be_o, mem_wdata_o} !== 100'h0) $display("FAIL reset_data wb=%h addr=%h be=%h wdata=%h want 0", wb_data_o, mem_addr_o, mem_be_o, mem_wdata_o); else n_pass++;
`ifdef LSU_MISALIGN_CHECK_EN
        n_total++; if (misalign_o !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign_o); else n_pass++;
`endif
        @(negedge clk);
        reset = 1'b0;
        model_wb = 32'h0;
    endtask

    task automatic test_sw_stall();
        run_op(OPC_SW, 32'h0000_0104, 32'hDEAD_BEEF, 3, 1, 32'h0, 2);
        n_total++; if (obs_stall !== 5) $display("FAIL sw_stall got %0d want 5", obs_stall); else n_pass++;
        n_total++; if (obs_req !== 1 || obs_extra_req !== 0) $display("FAIL sw_reqs got %0d+%0d want 1+0", obs_req, obs_extra_req); else n_pass++;
        n_total++; if ({obs_addr, obs_be, obs_we, obs_wdata} !== {32'h104, 4'hF, 1'b1, 32'hDEADBEEF}) $display("FAIL sw_fields addr=%h be=%h we=%b wdata=%h want 104 f 1 deadbeef", obs_addr, obs_be, obs_we, obs_wdata); else n_pass++;
        n_total++; if (obs_wb !== 0) $display("FAIL sw_wb got %0d want 0", obs_wb); else n_pass++;
    endtask

    task automatic test_lbu();
        run_op(OPC_LBU, 32'h0000_0203, 32'h0, 0, 2, 32'h8899_AABB, 2);
        model_wb = 32'h0000_0088;
        n_total++; if (obs_stall !== 4) $display("FAIL lbu_stall got %0d want 4", obs_stall); else n_pass++;
        n_total++; if (obs_wb !== 1 || obs_wb_in_done !== 1'b1) $display("FAIL lbu_wb_pulse count=%0d in_done=%b want 1 1", obs_wb, obs_wb_in_done); else n_pass++;
        n_total++; if (wb_data_o !== 32'h0000_0088) $display("FAIL lbu_data got %h want 00000088", wb_data_o); else n_pass++;
        n_total++; if ({obs_addr, obs_we} !== {32'h200, 1'b0}) $display("FAIL lbu_req addr=%h we=%b want 200 0", obs_addr, obs_we); else n_pass++;
    endtask

    task automatic test_sb();
        run_op(OPC_SB, 32'h0000_0011, 32'h1234_56C3, 0, 1, 32'h0, 1);
        n_total++; if ({obs_be, obs_wdata, obs_we} !== {4'b0010, 32'hC3C3C3C3, 1'b1}) $display("FAIL sb_fields be=%b wdata=%h we=%b want 0010 c3c3c3c3 1", obs_be, obs_wdata, obs_we); else n_pass++;
        n_total++; if (obs_stall !== 2) $display("FAIL sb_stall got %0d want 2", obs_stall); else n_pass++;
        n_total++; if (wb_data_o !== model_wb) $display("FAIL sb_wb_hold got %h want %h", wb_data_o, model_wb); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_op(OPC_LW, 32'h0000_0040, 32'h0, 0, 1, 32'hCAFE_0001, 0);
        n_total++; if (obs_stall !== 3 || obs_req !== 1 || obs_wb_in_done !== 1'b1) $display("FAIL b2b_first stall=%0d req=%0d wb=%b want 3 1 1", obs_stall, obs_req, obs_wb_in_done); else n_pass++;
        n_total++; if (obs_wb_data !== 32'hCAFE_0001) $display("FAIL b2b_first_data got %h want cafe0001", obs_wb_data); else n_pass++;
        run_op(OPC_LW, 32'h0000_0080, 32'h0, 1, 1, 32'hCAFE_0002, 2);
        model_wb = 32'hCAFE_0002;
        n_total++; if (obs_stall !== 4 || obs_req !== 1 || obs_extra_req !== 0) $display("FAIL b2b_second stall=%0d req=%0d extra=%0d want 4 1 0", obs_stall, obs_req, obs_extra_req); else n_pass++;
        n_total++; if (obs_addr !== 32'h80 || wb_data_o !== 32'hCAFE_0002) $display("FAIL b2b_second_data addr=%h data=%h want 80 cafe0002", obs_addr, wb_data_o); else n_pass++;
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        op_valid_i = 1'b1; op_i = '{opcode: OPC_LW, rd: 4'h1, rs: 4'h2};
        addr_i = 32'h0000_0300; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        mem_req_ready_i = 1'b1;
        #1;
        n_total++; if (mem_req_valid_o !== 1'b1) $display("FAIL rst_req_valid got %b want 1", mem_req_valid_o); else n_pass++;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        #1;
        n_total++; if (stall_o !== 1'b1) $display("FAIL rst_in_resp_stall got %b want 1", stall_o); else n_pass++;
        #1 reset = 1'b1;
        op_valid_i = 1'b0;
        #1;
        n_total++; if ({stall_o, wb_valid_o, mem_req_valid_o} !== 3'b000) $display("FAIL rst_async got %b want 000", {stall_o, wb_valid_o, mem_req_valid_o}); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        #1;
        n_total++; if ({stall_o, wb_valid_o} !== 2'b00) $display("FAIL rst_stray_rsp got %b want 00", {stall_o, wb_valid_o}); else n_pass++;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        #1;
        n_total++; if ({stall_o, wb_valid_o, mem_req_valid_o} !== 3'b000 || wb_data_o !== 32'h0) $display("FAIL rst_after got %b data=%h want 000 0", {stall_o, wb_valid_o, mem_req_valid_o}, wb_data_o); else n_pass++;
        model_wb = 32'h0;
    endtask

    task automatic test_ignored_op();
        int bad;
        bad = 0;
        @(negedge clk);
        op_valid_i = 1'b1; op_i = '{opcode: 8'h33, rd: 4'h3, rs: 4'h4};
        mem_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (stall_o || mem_req_valid_o || wb_valid_o) bad++;
        end
        op_valid_i = 1'b0; mem_req_ready_i = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL ignored_op active cycles=%0d want 0", bad); else n_pass++;
    endtask

`ifdef LSU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        run_op(OPC_LW, 32'h0000_0002, 32'h0, 0, 1, 32'hFFFF_FFFF, 2);
        model_wb = 32'h0;
        n_total++; if (obs_req !== 0 || obs_extra_req !== 0) $display("FAIL mis_req got %0d want 0", obs_req); else n_pass++;
        n_total++; if ({obs_mis_in_done, obs_wb_in_done} !== 2'b11 || obs_stall !== 1) $display("FAIL mis_done mis=%b wb=%b stall=%0d want 1 1 1", obs_mis_in_done, obs_wb_in_done, obs_stall); else n_pass++;
        n_total++; if (wb_data_o !== 32'h0 || misalign_o !== 1'b0) $display("FAIL mis_after data=%h mis=%b want 0 0", wb_data_o, misalign_o); else n_pass++;
    endtask
`endif

    // Random accesses against a plain-arithmetic model of the expected memory traffic
    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          k, rdly, rspd, exp_stall, exp_req;
            logic [7:0]  opc;
            logic [31:0] a, d, r, exp_wdata;
            logic [3:0]  exp_be;
            bit          ld, byt, mis;
            k    = int'($urandom_range(0, 3));
            a    = $urandom(); d = $urandom(); r = $urandom();
            rdly = int'($urandom_range(0, 3));
            rspd = int'($urandom_range(1, 3));
            ld   = (k < 2);
            byt  = (k == 1) || (k == 3);
            opc  = (k == 0) ? OPC_LW : (k == 1) ? OPC_LBU : (k == 2) ? OPC_SW : OPC_SB;
            mis  = 0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis  = !byt && (a % 4 != 0);
`endif
            run_op(opc, a, d, rdly, rspd, r, 2);
            exp_req   = mis ? 0 : 1;
            exp_stall = mis ? 1 : (ld ? 2 + rdly + rspd : 2 + rdly);
            exp_be    = byt ? 4'(1 << (a % 4)) : 4'hF;
            exp_wdata = byt ? (d & 32'hFF) * 32'h0101_0101 : d;
            if (ld) model_wb = mis ? 32'h0 : (byt ? (r >> (8 * (a % 4))) & 32'hFF : r);
            n_total++; if (obs_timeout !== 0 || obs_stall !== exp_stall) $display("FAIL rand%0d_stall got %0d (timeout %0d) want %0d", i, obs_stall, obs_timeout, exp_stall); else n_pass++;
            n_total++; if (obs_req !== exp_req || obs_extra_req !== 0) $display("FAIL rand%0d_reqs got %0d+%0d want %0d+0", i, obs_req, obs_extra_req, exp_req); else n_pass++;
            if (!mis) begin
                n_total++; if (obs_addr !== (a & 32'hFFFF_FFFC) || obs_we !== !ld) $display("FAIL rand%0d_addr got %h we=%b want %h %b", i, obs_addr, obs_we, a & 32'hFFFF_FFFC, !ld); else n_pass++;
                if (!ld) begin
                    n_total++; if (obs_be !== exp_be || obs_wdata !== exp_wdata) $display("FAIL rand%0d_store be=%h wdata=%h want %h %h", i, obs_be, obs_wdata, exp_be, exp_wdata); else n_pass++;
                end
            end
            n_total++; if (obs_wb !== ((ld && !(mis && byt)) ? 1 : 0)) $display("FAIL rand%0d_wb_count got %0d want %0d", i, obs_wb, ld ? 1 : 0); else n_pass++;
            n_total++; if (wb_data_o !== model_wb) $display("FAIL rand%0d_wb_data got %h want %h", i, wb_data_o, model_wb); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sw_stall();
        test_lbu();
        test_sb();
        test_back_to_back();
        test_ignored_op();
`ifdef LSU_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
